abro_scheduler: RTL
===================

# abro_scheduler

Time-multiplexed ABRO controller that shares one ABRO next-state core across `NUM_CH` independent requester channels. Each channel has its own A/B/R event inputs and its own O pulse. Per-channel context (2-bit state) lives in a register file, and a round-robin scheduler services one channel per cycle. It sits above the single-channel ABRO machine, replacing N copies with one core plus context storage.

## Interface

**Parameters**
- `NUM_CH`, default 4: number of channels; legal range ≥ 2, not required to be a power of 2.
- `PTR_W`, default `$clog2(NUM_CH)`: width of the scheduler pointer; derived, do not override.

**Ports**
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `a`  in  NUM_CH  per-channel A event, level-sampled each cycle.
- `b`  in  NUM_CH  per-channel B event.
- `r`  in  NUM_CH  per-channel restart.
- `o`  out  NUM_CH  per-channel O, registered one-cycle pulse.
- `state`  out  2*NUM_CH  context of channel i at `[2i+1:2i]`, registered.
- `svc_ptr`  out  PTR_W  scheduler pointer, registered.

## Operation

- **Per-channel states:** WAIT=2'b00, GOT_A=2'b01, GOT_B=2'b10, DONE=2'b11.
- **Effective events for channel i:** `ea = pend_a[i] | a[i]`, `eb = pend_b[i] | b[i]`, `er = pend_r[i] | r[i]`.
- **Pending bits:** sticky. Each cycle a non-serviced channel j does `pend_x[j] <= pend_x[j] | x[j]`. The serviced channel's three pending bits clear to 0.
- **Transitions on service**, with `er` taking priority over everything:
  - any state with `er` -> WAIT, no O.
  - WAIT: `ea & eb` -> DONE with O; `ea` only -> GOT_A; `eb` only -> GOT_B.
  - GOT_A: `eb` -> DONE with O.
  - GOT_B: `ea` -> DONE with O.
  - DONE: holds; `ea`/`eb` are discarded.
  - No events -> hold.
- **O pulse:** O for channel i is `o[i]=1` for exactly the cycle after the service edge that enters DONE. All other `o` bits are 0 that cycle.
- **Scheduling (default, fixed rotation):**
  - Served channel `svc = svc_ptr`.
  - `svc_ptr <= (svc == NUM_CH-1) ? 0 : svc+1` every cycle.
- **Reset:**
  - State: all contexts WAIT, all pending 0, `o=0`, `state=0`, `svc_ptr=0`.
  - Assertion mid-operation clears immediately (asynchronously) and drops in-flight events.
  - Inputs during reset are ignored.

## Timing

- Exactly one channel is serviced per clock, and the core is used once per cycle.
- **Latency from input to O:** 1 cycle when the completing event arrives while `svc_ptr == i`, worst case `NUM_CH` cycles.
- **Event capture:** a single-cycle event on any channel is never lost; it persists in its pending bit until serviced.
- **Coincident events:** multiple pulses of the same event before service coalesce into one.
- **Pointer wrap:** `NUM_CH-1` -> 0 with no skipped cycle.
- **Registered outputs:** `state` and `svc_ptr` update on the same edge as the context write.

## Configuration

- Macro `ABRO_SCHED_SKIP_EN` selects the scheduling mode.
- **Defined (work-conserving):**
  - `svc` is chosen combinationally as the first channel, circularly from `svc_ptr`, whose `ea|eb|er` is non-zero.
  - On service, `svc_ptr <= svc+1` (with wrap).
  - If no channel has events, nothing is serviced and `svc_ptr` holds.
  - Latency is 1 cycle for a lone active channel.
- **Undefined:** fixed rotation as described under Operation.

## Structure

- **Shared package `abro_pkg`:**
  - `abro_state_t` enum with encodings ABRO_WAIT / ABRO_GOT_A / ABRO_GOT_B / ABRO_DONE.
  - State width constant = 2.
- **Sub-module `abro_core`:**
  - Combinational.
  - Inputs: current state, `ea`, `eb`, `er`.
  - Outputs: next state, O strobe.
  - Instantiated once.
- **Top level holds:** context register file, pending bits, pointer/selection logic, and output registers.

## Test plan

All scenarios use `NUM_CH=4`.

1. **Reset:** `reset=0` with `a=4'hF`, `b=4'hF` -> `o=0`, `state=8'h00`, `svc_ptr=0`. Release with inputs 0 -> `o` stays 0 for 20 cycles.
2. **Ordered events:** 1-cycle `a[2]` pulse at `svc_ptr=0`, then 1-cycle `b[2]` pulse at `svc_ptr=3`:
   - `state[5:4]` = 01 after the first service of ch2.
   - `o[2]` pulses once, one cycle after the next ch2 service.
   - `state[5:4]` = 11.
3. **Simultaneous events:** `a[1]=b[1]=1` for one cycle while `svc_ptr==1` -> `o[1]=1` the next cycle only, `state[3:2]=11`.
4. **Restart priority:** ch1 in DONE.
   - `a[1]=b[1]=1` -> no `o`.
   - `r[1]` with `a[1]`, `b[1]` in the same cycle -> `state[3:2]=00`, no `o`.
5. **All channels, fixed rotation:** `a=b=4'hF` for one cycle at `svc_ptr=0` -> `o` = 0001, 0010, 0100, 1000 on the four following cycles.
6. **Work-conserving:** with `ABRO_SCHED_SKIP_EN`, `svc_ptr=0`, `a[3]=b[3]=1` for one cycle -> `o[3]` next cycle, `svc_ptr=0` (wrapped). With no further events, `svc_ptr` holds at 0.

Source files
------------

// File: rtl/abro_pkg.sv
// Shared ABRO definitions: per-channel state encoding and a circular index helper.
package abro_pkg;

   localparam int unsigned ABRO_STATE_W = 2;

   typedef enum logic [ABRO_STATE_W-1:0] {
      ABRO_WAIT  = 2'b00,
      ABRO_GOT_A = 2'b01,
      ABRO_GOT_B = 2'b10,
      ABRO_DONE  = 2'b11
   } abro_state_t;

   // (base + off) mod n, valid when base < n and off < n
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      int unsigned s;
      s = base + off;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/abro_core.sv
// Combinational single-channel ABRO next-state core, shared by all channels.
module abro_core
   import abro_pkg::*;
(
   input  abro_state_t cur,
   input  logic        ea,
   input  logic        eb,
   input  logic        er,
   output abro_state_t nxt_c,
   output logic        o_c
);

   always_comb begin
      nxt_c = cur;
      o_c   = 1'b0;
      if (er) begin
         nxt_c = ABRO_WAIT;
      end else begin
         case (cur)
            ABRO_WAIT: begin
               if (ea && eb) begin
                  nxt_c = ABRO_DONE;
                  o_c   = 1'b1;
               end else if (ea) begin
                  nxt_c = ABRO_GOT_A;
               end else if (eb) begin
                  nxt_c = ABRO_GOT_B;
               end
            end
            ABRO_GOT_A: begin
               if (eb) begin
                  nxt_c = ABRO_DONE;
                  o_c   = 1'b1;
               end
            end
            ABRO_GOT_B: begin
               if (ea) begin
                  nxt_c = ABRO_DONE;
                  o_c   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/abro_scheduler.sv
// Time-multiplexed ABRO controller: one shared core, per-channel context and sticky events.
// ABRO_SCHED_SKIP_EN selects work-conserving scheduling instead of fixed rotation.
module abro_scheduler
   import abro_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned PTR_W  = $clog2(NUM_CH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          a,
   input  logic [NUM_CH-1:0]          b,
   input  logic [NUM_CH-1:0]          r,
   output logic [NUM_CH-1:0]          o,
   output logic [2*NUM_CH-1:0]        state,
   output logic [PTR_W-1:0]           svc_ptr
);

   logic [NUM_CH-1:0][ABRO_STATE_W-1:0] ctx, ctx_nxt;
   logic [NUM_CH-1:0] pend_a, pend_b, pend_r;
   logic [NUM_CH-1:0] pend_a_nxt, pend_b_nxt, pend_r_nxt;
   logic [NUM_CH-1:0] ea, eb, er;
   logic [NUM_CH-1:0] o_nxt;
   logic [PTR_W-1:0]  svc, svc_inc, ptr_nxt;
   logic              svc_vld;
   abro_state_t       cur, nxt;
   logic              fire;

   assign state = ctx;

   // Channel selection
`ifdef ABRO_SCHED_SKIP_EN
   logic [NUM_CH-1:0] act;

   always_comb begin
      ea      = pend_a | a;
      eb      = pend_b | b;
      er      = pend_r | r;
      act     = ea | eb | er;
      svc     = svc_ptr;
      svc_vld = 1'b0;
      // Walk backwards so the nearest active channel from svc_ptr wins
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
         if (act[PTR_W'(wrap_add(int'(svc_ptr), k, NUM_CH))]) begin
            svc     = PTR_W'(wrap_add(int'(svc_ptr), k, NUM_CH));
            svc_vld = 1'b1;
         end
      end
   end
`else
   always_comb begin
      ea      = pend_a | a;
      eb      = pend_b | b;
      er      = pend_r | r;
      svc     = svc_ptr;
      svc_vld = 1'b1;
   end
`endif

   assign cur     = abro_state_t'(ctx[svc]);
   assign svc_inc = (svc == PTR_W'(NUM_CH - 1)) ? '0 : svc + PTR_W'(1);

   abro_core u_core (
      .cur   (cur),
      .ea    (ea[svc]),
      .eb    (eb[svc]),
      .er    (er[svc]),
      .nxt_c (nxt),
      .o_c   (fire)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctx     <= '0;
         pend_a  <= '0;
         pend_b  <= '0;
         pend_r  <= '0;
         svc_ptr <= '0;
         o       <= '0;
      end else begin
         ctx     <= ctx_nxt;
         pend_a  <= pend_a_nxt;
         pend_b  <= pend_b_nxt;
         pend_r  <= pend_r_nxt;
         svc_ptr <= ptr_nxt;
         o       <= o_nxt;
      end
   end

   // Next context, pending bits and pointer
   always_comb begin
      ctx_nxt    = ctx;
      pend_a_nxt = pend_a | a;
      pend_b_nxt = pend_b | b;
      pend_r_nxt = pend_r | r;
      ptr_nxt    = svc_ptr;
      if (svc_vld) begin
         ctx_nxt[svc]    = nxt;
         pend_a_nxt[svc] = 1'b0;
         pend_b_nxt[svc] = 1'b0;
         pend_r_nxt[svc] = 1'b0;
         ptr_nxt         = svc_inc;
      end
   end

   // O pulse for the serviced channel
   always_comb begin
      o_nxt = '0;
      if (svc_vld && fire) begin
         o_nxt[svc] = 1'b1;
      end
   end

endmodule
